k_of_n_checker: RTL

Serial checker for generalised K-of-N codewords (default 2-of-5). It receives one bit per enabled cycle, LSB first, and uses a bit-position counter and a ones counter. It flags each completed N-bit frame as valid (exactly K ones) or invalid. It sits on the serial receive path, captures each completed word for downstream decode, and keeps a saturating error count.

---
 rtl/k_of_n_pkg.sv | 20 ++
 rtl/sat_counter.sv | 38 +++
 rtl/k_of_n_checker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/k_of_n_pkg.sv
// Shared types and parameter checks for the K-of-N serial codeword checker.
//   st_e         : checker FSM state (ST_COUNT, ST_OVER)
//   n_bits_ok()  : codeword length is legal (>= 2)
//   k_ones_ok()  : ones target is legal (1..n)
package k_of_n_pkg;

    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,  // ones seen so far <= K
        ST_OVER  = 1'b1   // more than K ones seen, frame already invalid
    } st_e;

    function automatic bit n_bits_ok(int unsigned n);
        return n >= 2;
    endfunction

    function automatic bit k_ones_ok(int unsigned n, int unsigned k);
        return (k >= 1) && (k <= n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, reset_l : clock, asynchronous active-low reset
//   inc          : count up by one unless already at MAX
//   clr          : synchronous clear to zero
//   cnt          : current count
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/k_of_n_checker.sv
// Serial K-of-N codeword checker. Bits arrive LSB first, one per enabled cycle;
// each completed N_BITS frame is flagged valid when it holds exactly K_ONES ones.
//   clk, reset_l : clock, asynchronous active-low reset
//   sync_clr     : discard the partial frame and realign (wins over in_en)
//   in_en, in    : serial bit strobe and data
//   valid        : combinational, last bit of a frame with exactly K ones
//   frame_done   : combinational, last bit of a frame
//   word         : last completed frame, first-received bit at word[0]
//   word_ok      : 1-cycle pulse after completion, frame was valid
//   word_stb     : 1-cycle pulse after every completion
//   err_count    : saturating count of invalid frames
module k_of_n_checker
    import k_of_n_pkg::*;
#(
    parameter int unsigned N_BITS = 5,
    parameter int unsigned K_ONES = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              sync_clr,
    input  logic              in_en,
    input  logic              in,
    output logic              valid,
    output logic              frame_done,
    output logic [N_BITS-1:0] word,
    output logic              word_ok,
    output logic              word_stb,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned BW = $clog2(N_BITS);
    localparam int unsigned OW = $clog2(K_ONES + 2);

    localparam logic [BW-1:0] LAST_POS  = BW'(N_BITS - 1);
    localparam logic [OW-1:0] K_VAL     = OW'(K_ONES);
    localparam logic [OW-1:0] K_VAL_M1  = OW'(K_ONES - 1);
    localparam logic [OW-1:0] ONES_MAX  = OW'(K_ONES + 1);

    if (!n_bits_ok(N_BITS) || !k_ones_ok(N_BITS, K_ONES)) begin : g_param_err
        $error("k_of_n_checker: illegal N_BITS/K_ONES combination");
    end

    st_e               state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [N_BITS-1:0] sh_q, sh_d;
    logic [N_BITS-1:0] word_q;
    logic              word_ok_q, word_stb_q;
    logic [OW-1:0]     ones_cnt;

    logic accept, last_bit, ones_eq_k, ones_eq_km1, ones_gt_k;
    logic cnt_inc, cnt_clr, ones_inc, shift_en, word_ld, err_inc;
    logic [N_BITS-1:0] sh_next;

    // Status points. reset_l gates accept so the Mealy outputs read 0 in reset.
    assign accept      = reset_l && in_en && !sync_clr;
    assign last_bit    = (bit_cnt_q == LAST_POS);
    assign ones_eq_k   = (ones_cnt == K_VAL);
    assign ones_eq_km1 = (ones_cnt == K_VAL_M1);
    assign ones_gt_k   = (ones_cnt > K_VAL);

    assign sh_next = {in, sh_q[N_BITS-1:1]};

    // Mealy outputs: the incoming bit is folded into the ones test directly.
    assign frame_done = accept && last_bit;
    assign valid      = frame_done && (state_q == ST_COUNT) && !ones_gt_k &&
                        (in ? ones_eq_km1 : ones_eq_k);

    // Control points.
    assign shift_en = accept;
    assign word_ld  = frame_done;
    assign cnt_inc  = accept && !last_bit;
    assign cnt_clr  = sync_clr || word_ld;
    assign ones_inc = accept && in && (state_q == ST_COUNT) && !last_bit;
    assign err_inc  = word_ld && !valid;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (cnt_clr) begin
            bit_cnt_d = '0;
        end else if (cnt_inc) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end
    end

    always_comb begin
        sh_d = sh_q;
        if (shift_en) begin
            sh_d = sh_next;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cnt_clr) begin
            state_d = ST_COUNT;
        end else if (accept && in && (state_q == ST_COUNT) && ones_eq_k) begin
            state_d = ST_OVER;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_COUNT;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            word_q     <= '0;
            word_ok_q  <= 1'b0;
            word_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            word_ok_q  <= valid;
            word_stb_q <= word_ld;
            if (word_ld) begin
                word_q <= sh_next;
            end
        end
    end

    // Ones counter parks at K+1 once a frame goes over; ST_OVER stops further incs.
    sat_counter #(
        .W   (OW),
        .MAX (ONES_MAX)
    ) u_ones_cnt (
        .clk     (clk),
        .reset_l (reset_l),
        .inc     (ones_inc),
        .clr     (cnt_clr),
        .cnt     (ones_cnt)
    );

    sat_counter #(
        .W   (ERR_W),
        .MAX ({ERR_W{1'b1}})
    ) u_err_cnt (
        .clk     (clk),
        .reset_l (reset_l),
        .inc     (err_inc),
        .clr     (1'b0),
        .cnt     (err_count)
    );

    assign word     = word_q;
    assign word_ok  = word_ok_q;
    assign word_stb = word_stb_q;

endmodule
